fft_r2sdf_stage: RTL and testbench

//  One radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency stage of the feature extractor FFT.

---
 rtl/fft_r2sdf_stage.sv | 153 +++++++++++++++
 tb/tb_fft_r2sdf_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_r2sdf_stage.sv
// rtl/fft_r2sdf_stage.sv - radix-2 single-path delay-feedback DIF FFT stage
// Purpose: one R2SDF butterfly stage with delay line of depth
//   D = N_FFT >> (NO_STAGE+1). The difference path is multiplied by twiddles
//   prefetched from an external 1-cycle-latency twiddle bank.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_re/in_im     input sample stream, no backpressure
//   out_valid/out_re/out_im  output sample stream, registered
//   tw_ren/tw_addr           twiddle bank read request for the next sample
//   Re_twddle/Im_twddle      twiddle presented by the bank
module fft_r2sdf_stage #(
  parameter int DATA_WIDTH      = 16,
  parameter int TW_BIT_WIDTH    = 8,
  parameter int N_FFT           = 256,
  parameter int NO_STAGE        = 0,
  parameter int BANK_ADDR_WIDTH = ((N_FFT >> (NO_STAGE + 1)) > 1) ?
                                  $clog2(N_FFT >> (NO_STAGE + 1)) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic signed [DATA_WIDTH-1:0]      in_re,
  input  logic signed [DATA_WIDTH-1:0]      in_im,
  output logic                              out_valid,
  output logic signed [DATA_WIDTH-1:0]      out_re,
  output logic signed [DATA_WIDTH-1:0]      out_im,
  output logic                              tw_ren,
  output logic        [BANK_ADDR_WIDTH-1:0] tw_addr,
  input  logic signed [TW_BIT_WIDTH-1:0]    Re_twddle,
  input  logic signed [TW_BIT_WIDTH-1:0]    Im_twddle
);

  localparam int D  = N_FFT >> (NO_STAGE + 1);
  localparam int CW = $clog2(2 * D);
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int DL = 1 << IW;
  localparam int PW = DATA_WIDTH + TW_BIT_WIDTH + 1;
  localparam int SH = TW_BIT_WIDTH - 2;

  localparam logic        [CW:0]   D_W     = (CW + 1)'(D);
  localparam logic        [CW:0]   D2_W    = (CW + 1)'(2 * D);
  localparam logic signed [PW-1:0] RND     = PW'(1 << (TW_BIT_WIDTH - 3));
  localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

  logic        [CW-1:0]         cnt_q, cnt_d;
  logic        [CW:0]           cnt_inc;
  logic                         prime_q;
  logic                         out_valid_q;
  logic signed [DATA_WIDTH-1:0] out_re_q, out_im_q, out_re_d, out_im_d;
  logic signed [DATA_WIDTH-1:0] dl_re_q [DL];
  logic signed [DATA_WIDTH-1:0] dl_im_q [DL];
  logic        [IW-1:0]         idx;
  logic                         second_half;
  logic signed [DATA_WIDTH-1:0] head_re, head_im;
  logic signed [DATA_WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [DATA_WIDTH-1:0] s_re, s_im, d_re, d_im;
  logic signed [PW-1:0]         pr_full, pi_full, pr_rnd, pi_rnd;
  logic signed [DATA_WIDTH-1:0] push_re, push_im;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] x);
    if (x > SAT_MAX) begin
      return DATA_WIDTH'(SAT_MAX);
    end else if (x < SAT_MIN) begin
      return DATA_WIDTH'(SAT_MIN);
    end
    return DATA_WIDTH'(x);
  endfunction

  // The delay line is a circular buffer: the slot for position cnt mod D was
  // written exactly D accepted samples ago, so it is the FIFO head.
  generate
    if (D > 1) begin : g_idx
      assign idx = cnt_q[IW-1:0];
    end else begin : g_idx1
      assign idx = '0;
    end
  endgenerate

  assign second_half = cnt_q[CW-1];
  assign head_re     = dl_re_q[idx];
  assign head_im     = dl_im_q[idx];
  assign cnt_inc     = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    sum_re  = {head_re[DATA_WIDTH-1], head_re} + {in_re[DATA_WIDTH-1], in_re};
    sum_im  = {head_im[DATA_WIDTH-1], head_im} + {in_im[DATA_WIDTH-1], in_im};
    dif_re  = {head_re[DATA_WIDTH-1], head_re} - {in_re[DATA_WIDTH-1], in_re};
    dif_im  = {head_im[DATA_WIDTH-1], head_im} - {in_im[DATA_WIDTH-1], in_im};
    // Halving keeps the butterfly result within DATA_WIDTH bits.
    s_re    = DATA_WIDTH'(sum_re >>> 1);
    s_im    = DATA_WIDTH'(sum_im >>> 1);
    d_re    = DATA_WIDTH'(dif_re >>> 1);
    d_im    = DATA_WIDTH'(dif_im >>> 1);
    pr_full = PW'(d_re) * PW'(Re_twddle) - PW'(d_im) * PW'(Im_twddle);
    pi_full = PW'(d_re) * PW'(Im_twddle) + PW'(d_im) * PW'(Re_twddle);
    pr_rnd  = (pr_full + RND) >>> SH;
    pi_rnd  = (pi_full + RND) >>> SH;
    out_re_d = head_re;
    out_im_d = head_im;
    push_re  = in_re;
    push_im  = in_im;
    if (second_half) begin
      out_re_d = s_re;
      out_im_d = s_im;
      push_re  = sat(pr_rnd);
      push_im  = sat(pi_rnd);
    end
  end

  // Twiddle prefetch: the read issued with sample cnt lands in the bank
  // output register in time for sample cnt+1, even with gaps in between.
  always_comb begin
    tw_ren  = 1'b0;
    tw_addr = '0;
    if (!rst) begin
      tw_ren = prime_q | in_valid;
      if (in_valid && cnt_inc >= D_W && cnt_inc < D2_W) begin
        tw_addr = BANK_ADDR_WIDTH'(cnt_inc - D_W);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      prime_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      for (int k = 0; k < DL; k++) begin
        dl_re_q[k] <= '0;
        dl_im_q[k] <= '0;
      end
    end else begin
      prime_q     <= 1'b0;
      out_valid_q <= in_valid;
      if (in_valid) begin
        cnt_q        <= cnt_d;
        out_re_q     <= out_re_d;
        out_im_q     <= out_im_d;
        dl_re_q[idx] <= push_re;
        dl_im_q[idx] <= push_im;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// tb/tb_fft_r2sdf_stage.sv - self-checking bench for fft_r2sdf_stage (D=1 and D=4)
module tb_fft_r2sdf_stage;

  localparam int DB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instance A: D = 1 ----------------
  logic               rst_a, v_a, ov_a, ren_a;
  logic signed [15:0] re_a, im_a, ore_a, oim_a;
  logic        [0:0]  addr_a;
  logic signed [7:0]  wre_a, wim_a, romw_re_a, romw_im_a;

  fft_r2sdf_stage #(.DATA_WIDTH(16), .TW_BIT_WIDTH(8), .N_FFT(256), .NO_STAGE(7)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(v_a), .in_re(re_a), .in_im(im_a),
    .out_valid(ov_a), .out_re(ore_a), .out_im(oim_a),
    .tw_ren(ren_a), .tw_addr(addr_a), .Re_twddle(wre_a), .Im_twddle(wim_a));

  always @(posedge clk) if (ren_a) begin
    wre_a <= romw_re_a;
    wim_a <= romw_im_a;
  end

  // ---------------- instance B: D = 4 ----------------
  logic               rst_b, v_b, ov_b, ren_b;
  logic signed [15:0] re_b, im_b, ore_b, oim_b;
  logic        [1:0]  addr_b;
  logic signed [7:0]  wre_b, wim_b;
  int tw_tab_re [DB] = '{64, 45, 0, -45};
  int tw_tab_im [DB] = '{0, -45, -64, -45};

  fft_r2sdf_stage #(.DATA_WIDTH(16), .TW_BIT_WIDTH(8), .N_FFT(256), .NO_STAGE(5)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(v_b), .in_re(re_b), .in_im(im_b),
    .out_valid(ov_b), .out_re(ore_b), .out_im(oim_b),
    .tw_ren(ren_b), .tw_addr(addr_b), .Re_twddle(wre_b), .Im_twddle(wim_b));

  always @(posedge clk) if (ren_b) begin
    wre_b <= 8'(tw_tab_re[addr_b]);
    wim_b <= 8'(tw_tab_im[addr_b]);
  end

  // ---------------- scoreboards ----------------
  int exp_a_re[$], exp_a_im[$], exp_b_re[$], exp_b_im[$];
  int cap_re[$], cap_im[$], addr_log[$];
  int ren_cnt = 0;

  always @(negedge clk) begin : mon_a
    int er, ei;
    if (ov_a) begin
      if (exp_a_re.size() == 0) check("a_unexpected_out", 1, 0);
      else begin
        er = exp_a_re.pop_front();
        ei = exp_a_im.pop_front();
        check("a_out_re", ore_a, er);
        check("a_out_im", oim_a, ei);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    int er, ei;
    if (!rst_b && ren_b) ren_cnt++;
    if (ov_b) begin
      cap_re.push_back(int'(ore_b));
      cap_im.push_back(int'(oim_b));
      if (exp_b_re.size() == 0) check("b_unexpected_out", 1, 0);
      else begin
        er = exp_b_re.pop_front();
        ei = exp_b_im.pop_front();
        check("b_out_re", ore_b, er);
        check("b_out_im", oim_b, ei);
      end
    end
  end

  // ---------------- reference model for B (FIFO delay line) ----------------
  int m_dl_re[$], m_dl_im[$];
  int m_cnt;

  function automatic void model_reset();
    m_dl_re.delete();
    m_dl_im.delete();
    for (int k = 0; k < DB; k++) begin
      m_dl_re.push_back(0);
      m_dl_im.push_back(0);
    end
    m_cnt = 0;
  endfunction

  function automatic int sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic void model_step(input int xr, input int xi);
    longint ar, ai, dr, di, pr, pi;
    int j;
    ar = m_dl_re.pop_front();
    ai = m_dl_im.pop_front();
    if (m_cnt < DB) begin
      exp_b_re.push_back(int'(ar));
      exp_b_im.push_back(int'(ai));
      m_dl_re.push_back(xr);
      m_dl_im.push_back(xi);
    end else begin
      j  = m_cnt - DB;
      exp_b_re.push_back(int'((ar + xr) >>> 1));
      exp_b_im.push_back(int'((ai + xi) >>> 1));
      dr = (ar - xr) >>> 1;
      di = (ai - xi) >>> 1;
      pr = dr * tw_tab_re[j] - di * tw_tab_im[j];
      pi = dr * tw_tab_im[j] + di * tw_tab_re[j];
      m_dl_re.push_back(sat16((pr + 32) >>> 6));
      m_dl_im.push_back(sat16((pi + 32) >>> 6));
    end
    m_cnt = (m_cnt + 1) % (2 * DB);
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  // ---------------- drivers ----------------
  task automatic reset_a();
    rst_a = 1'b1; v_a = 1'b0; re_a = '0; im_a = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_a(input int xr, input int xi, input int er, input int ei);
    v_a = 1'b1; re_a = 16'(xr); im_a = 16'(xi);
    exp_a_re.push_back(er);
    exp_a_im.push_back(ei);
    #1;
    check("a_tw_addr_zero", addr_a, 0);
    @(posedge clk); #1;
    v_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1; v_b = 1'b0; re_b = '0; im_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("b_rst_out_valid", ov_b, 0);
    check("b_rst_out_re", ore_b, 0);
    check("b_rst_out_im", oim_b, 0);
    check("b_rst_tw_ren", ren_b, 0);
    check("b_rst_tw_addr", addr_b, 0);
    model_reset();
    ren_cnt = 0;
    cap_re.delete(); cap_im.delete(); addr_log.delete();
    rst_b = 1'b0;
    #1;
    check("b_prime_ren", ren_b, 1);
    check("b_prime_addr", addr_b, 0);
    @(posedge clk); #1;
    check("b_prime_done_ren", ren_b, 0);
  endtask

  task automatic send_b(input bit v, input int xr, input int xi);
    v_b = v; re_b = 16'(xr); im_b = 16'(xi);
    if (v) model_step(xr, xi);
    #1;
    if (v) addr_log.push_back(int'(addr_b));
    @(posedge clk); #1;
    v_b = 1'b0;
  endtask

  // ---------------- vectors for A ----------------
  typedef struct {
    int ar, ai, br, bi, wr, wi, sr, si, pr, pi;
  } vec_t;

  initial begin
    vec_t vt [6];
    int xr [24], xi [24], ref_re [$], ref_im [$];
    int exp_addr [8] = '{0, 0, 0, 0, 1, 2, 3, 0};

    vt[0] = '{100, 0, 20, 0, 64, 0, 60, 0, 40, 0};
    vt[1] = '{6, 0, 0, 0, 45, 45, 3, 0, 2, 2};
    vt[2] = '{32767, 32767, -32768, -32768, 45, -45, -1, -1, 32767, 0};
    vt[3] = '{-3, 5, 0, 0, 64, 0, -2, 2, -2, 2};
    vt[4] = '{-32768, 0, 32767, 0, 127, -128, -1, 0, -32768, 32767};
    vt[5] = '{1000, -500, 200, 300, 45, -45, 600, -100, 0, -562};

    rst_a = 1'b1; v_a = 1'b0; re_a = '0; im_a = '0; romw_re_a = '0; romw_im_a = '0;
    rst_b = 1'b1; v_b = 1'b0; re_b = '0; im_b = '0;

    // D=1 table: fill, butterfly, fill (weighted difference), butterfly of zeros
    for (int i = 0; i < 6; i++) begin
      romw_re_a = 8'(vt[i].wr);
      romw_im_a = 8'(vt[i].wi);
      reset_a();
      send_a(vt[i].ar, vt[i].ai, 0, 0);
      send_a(vt[i].br, vt[i].bi, vt[i].sr, vt[i].si);
      send_a(0, 0, vt[i].pr, vt[i].pi);
      send_a(0, 0, 0, 0);
      @(posedge clk); #1;
      check("a_sb_drain", exp_a_re.size(), 0);
    end

    // D=4 impulse over two frames plus tw_addr prefetch sequence
    reset_b();
    send_b(1'b1, 1000, 0);
    for (int k = 1; k < 16; k++) send_b(1'b1, 0, 0);
    send_b(1'b0, 0, 0);
    for (int k = 0; k < 8; k++) check("b_tw_addr_seq", addr_log[k], exp_addr[k]);
    check("b_imp_count", cap_re.size(), 16);
    if (cap_re.size() == 16) begin
      check("b_imp_s", cap_re[4], 500);
      check("b_imp_w0", cap_re[8], 500);
      check("b_imp_w0_im", cap_im[8], 0);
      check("b_imp_w1", cap_re[9], 0);
    end
    check("b_sb_drain", exp_b_re.size(), 0);

    // contiguous random run, then the same data with random gaps
    for (int k = 0; k < 24; k++) begin
      xr[k] = rnd16();
      xi[k] = rnd16();
    end
    reset_b();
    for (int k = 0; k < 24; k++) send_b(1'b1, xr[k], xi[k]);
    send_b(1'b0, 0, 0);
    ref_re = cap_re;
    ref_im = cap_im;
    check("b_ren_count_contig", ren_cnt, 25);
    reset_b();
    for (int k = 0; k < 24; k++) begin
      while ($urandom_range(0, 99) < 30) send_b(1'b0, rnd16(), rnd16());
      send_b(1'b1, xr[k], xi[k]);
    end
    send_b(1'b0, 0, 0);
    check("b_gap_count", cap_re.size(), 24);
    if (cap_re.size() == 24 && ref_re.size() == 24) begin
      for (int k = 0; k < 24; k++) begin
        check("b_gap_re", cap_re[k], ref_re[k]);
        check("b_gap_im", cap_im[k], ref_im[k]);
      end
    end
    check("b_ren_count_gap", ren_cnt, 25);
    check("b_sb_drain", exp_b_re.size(), 0);

    // reset in the middle of a frame, with in_valid also high
    reset_b();
    for (int k = 0; k < 6; k++) send_b(1'b1, rnd16(), rnd16());
    rst_b = 1'b1; v_b = 1'b1; re_b = 16'sd1234; im_b = -16'sd77;
    @(posedge clk); #1;
    check("b_midrst_out_valid", ov_b, 0);
    check("b_midrst_out_re", ore_b, 0);
    check("b_midrst_tw_ren", ren_b, 0);
    rst_b = 1'b0; v_b = 1'b0;
    model_reset();
    #1;
    check("b_midrst_prime_ren", ren_b, 1);
    check("b_midrst_prime_addr", addr_b, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) send_b(1'b1, rnd16(), rnd16());
    send_b(1'b0, 0, 0);
    check("b_sb_drain", exp_b_re.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
